// File: rtl/uart_rx_deframer_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive deframer.
//   state_t      : receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   START_BIT    : line level of a start bit
//   STOP_BIT     : line level of a valid stop bit
//   IDLE_LEVEL   : line level when nothing is being sent
//   calc_parity  : XOR-reduce a data word, optionally inverted for odd parity
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Widest data word supported; narrower words are zero-extended, which
    // leaves the XOR reduction unchanged.
    localparam int MAX_DATA_BITS = 9;

    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer_if
// Host-side output bundle of the UART receive deframer.
//   rx_data    : received word, holds until the next rx_valid
//   rx_valid   : one-cycle pulse, frame complete
//   parity_err : parity mismatch on the last frame
//   frame_err  : stop bit sampled low on the last frame
//   rx_busy    : receiver is inside a frame (state != IDLE)
//   dbg_state  : current receiver FSM state, for observation only
// Handshake: receive-only, no back-pressure. rx_valid is high for exactly one
// cycle per delivered frame; rx_data, parity_err and frame_err are valid in
// that cycle and hold their values until the next rx_valid. The consumer has
// no ready signal and must take the word in the rx_valid cycle.
// Modports: master = deframer (drives everything), slave = host logic.
// -----------------------------------------------------------------------------
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;
    state_t               dbg_state;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, rx_busy, dbg_state
    );

    modport slave (
        input rx_data, rx_valid, parity_err, frame_err, rx_busy, dbg_state
    );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and flags the
// falling edge that marks a possible start bit.
//   clk, rst_n : system clock, synchronous active-low reset
//   rx_in      : raw asynchronous serial line (idle high)
//   rx_s       : synchronised line level
//   fall_edge  : one-cycle flag, synchronised line just went 1 -> 0
// All three flops reset to the idle level so leaving reset never looks like
// a start edge.
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_edge
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s      = sync_q;
    // A line held low never produces a second edge: prev_q follows it down.
    assign fall_edge = (sync_q == START_BIT) && (prev_q == IDLE_LEVEL);

endmodule

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
// UART receiver: start (0), DATA_BITS data bits LSB first, optional parity,
// stop (1). Each bit is sampled at its mid-point using a per-bit cycle counter.
//   clk, rst_n : system clock, synchronous active-low reset
//   RX_datain  : asynchronous serial line, idle high
//   rx_if      : master side of uart_rx_deframer_if (rx_data, rx_valid,
//                parity_err, frame_err, rx_busy, dbg_state)
// Parameters: CLKS_PER_BIT (>= 4), DATA_BITS (5..9), PARITY_ODD (0 even, 1 odd).
// Build option: define UART_RX_PARITY_EN to include the parity bit in the
// frame. Without it the frame is start + data + stop, parity_err stays 0 and
// PARITY_ODD has no effect.
// -----------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RX_datain,
    uart_rx_deframer_if.master rx_if
);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    logic rx_s;
    logic fall_edge;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (RX_datain),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    state_t               state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 perr_q,       perr_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;

    logic                     bit_end;
    logic [MAX_DATA_BITS-1:0] par_word;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign par_word = MAX_DATA_BITS'(shift_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        // Free-running bit timer while inside a frame; wraps every bit period.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall_edge) begin
                    state_d = START;
                end
            end
            START: begin
                // Half a bit after the edge: re-check the line to reject glitches.
                // Clearing the counter here puts every later sample mid-bit.
                if (cnt_q == CNT_MID) begin
                    if (rx_s == START_BIT) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    perr_d  = calc_parity(par_word, ODD) ^ rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Deliver even on a bad stop bit; IDLE then waits for the line
                // to go high before a fresh edge can be seen.
                if (bit_end) begin
                    state_d      = IDLE;
                    rx_valid_d   = 1'b1;
                    rx_data_d    = shift_q;
                    parity_err_d = PAR_EN ? perr_q : 1'b0;
                    frame_err_d  = (rx_s != STOP_BIT);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.rx_busy    = (state_q != IDLE);
    assign rx_if.dbg_state  = state_q;

endmodule
